// File: rtl/button_step_gen.sv
// rtl/button_step_gen.sv - debounced pushbutton to step pulse generator with auto-repeat
//
// Turns two raw, bouncing pushbuttons (up / down) into single-cycle step
// pulses for a downstream up/down counter. A qualified press fires one step
// immediately, then auto-repeats while the button stays held. Releases are
// debounced too and never produce a step.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles that qualify a press or release
//   REPEAT_DELAY    - cycles from the first step pulse to the first repeat pulse
//   REPEAT_PERIOD   - cycles between repeat pulses
//   CNT_W           - timing counter width, must hold the largest of the above
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous active-low reset
//   enable    - when low no step pulses are produced
//   btn_up    - raw asynchronous "increment" button
//   btn_down  - raw asynchronous "decrement" button
//   step_en   - one-cycle step pulse (downstream counter enable)
//   up_down   - step direction, 1 = up, 0 = down; only changes with a pulse
//   held      - high while a qualified press is active

module button_step_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 5,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn_up,
    input  logic btn_down,
    output logic step_en,
    output logic up_down,
    output logic held
);

    // Terminal counter values. The counter starts at 0 on entry to a state, so
    // the last value before acting is N-1. Repeat timings are floored at 2 so
    // step_en can never be high on two consecutive cycles.
    localparam int DB_LAST_I = (DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1;
    localparam int RD_LAST_I = (REPEAT_DELAY    < 2) ? 1 : REPEAT_DELAY - 1;
    localparam int RP_LAST_I = (REPEAT_PERIOD   < 2) ? 1 : REPEAT_PERIOD - 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_LAST_I);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LAST_I);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RP_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        FIRE       = 3'd2,
        HOLD_WAIT  = 3'd3,
        REPEAT     = 3'd4,
        RELEASE_DB = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             step_en_q, step_en_d;
    logic             up_down_q, up_down_d;
    logic             held_q, held_d;

    logic [1:0]       up_sync_q;
    logic [1:0]       dn_sync_q;

    logic             up_s;
    logic             dn_s;
    logic             act_s;
    logic             oth_s;
    logic [CNT_W-1:0] cnt_inc;

    // Two-flop synchronizers; nothing else ever looks at the raw buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            up_sync_q <= 2'b00;
            dn_sync_q <= 2'b00;
        end else begin
            up_sync_q <= {up_sync_q[0], btn_up};
            dn_sync_q <= {dn_sync_q[0], btn_down};
        end
    end

    assign up_s = up_sync_q[1];
    assign dn_s = dn_sync_q[1];

    // Active button is the one latched at press time; the other one counts
    // as interference.
    assign act_s = dir_q ? up_s : dn_s;
    assign oth_s = dir_q ? dn_s : up_s;

    // Saturating increment so a long hold never wraps the counter.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            dir_q     <= 1'b1;
            step_en_q <= 1'b0;
            up_down_q <= 1'b1;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            step_en_q <= step_en_d;
            up_down_q <= up_down_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        step_en_d = 1'b0;
        up_down_d = up_down_q;

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                // Exactly one button: both or neither is ambiguous.
                if (enable && (up_s ^ dn_s)) begin
                    dir_d   = up_s;
                    state_d = PRESS_DB;
                end
            end

            PRESS_DB: begin
                if (enable && act_s && !oth_s) begin
                    if (cnt_q >= DB_LAST) begin
                        state_d = FIRE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end

            FIRE: begin
                // Pulse and direction update land together in the output
                // registers on the next edge.
                if (enable) begin
                    step_en_d = 1'b1;
                    up_down_d = dir_q;
                end
                state_d = HOLD_WAIT;
                cnt_d   = CNT_ZERO;
            end

            HOLD_WAIT: begin
                if (!enable || !act_s || oth_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= RD_LAST) begin
                    step_en_d = 1'b1;
                    up_down_d = dir_q;
                    state_d   = REPEAT;
                    cnt_d     = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            REPEAT: begin
                if (!enable || !act_s || oth_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= RP_LAST) begin
                    step_en_d = 1'b1;
                    up_down_d = dir_q;
                    cnt_d     = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RELEASE_DB: begin
                // Both buttons must read low for a full debounce window; any
                // high sample starts the window over.
                if (up_s || dn_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        held_d = (state_d == FIRE) || (state_d == HOLD_WAIT) || (state_d == REPEAT);
    end

    assign step_en = step_en_q;
    assign up_down = up_down_q;
    assign held    = held_q;

endmodule

// File: tb/tb_button_step_gen.sv
// tb/tb_button_step_gen.sv - directed self-checking bench for button_step_gen

module tb_button_step_gen;

    logic clk;
    logic reset;
    logic enable;
    logic btn_up;
    logic btn_down;
    logic step_en;
    logic up_down;
    logic held;

    int errors;
    int checks;
    int cyc;
    int pulse_cyc[$];
    int pulse_dir[$];
    int held_seen;
    int dbl_pulse;
    int ud_bad;
    logic prev_step;
    logic prev_ud;
    int p0;
    int exp_off[5];

    button_step_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5),
        .CNT_W          (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .step_en (step_en),
        .up_down (up_down),
        .held    (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the rising edge and log pulses/invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step_en === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_dir.push_back(int'(up_down));
        end
        if (held === 1'b1) held_seen = 1;
        if (step_en === 1'b1 && prev_step === 1'b1) dbl_pulse++;
        if (reset === 1'b1 && step_en !== 1'b1 && up_down !== prev_ud) ud_bad++;
        prev_step = step_en;
        prev_ud   = up_down;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_dir.delete();
        held_seen = 0;
    endtask

    function automatic int pc(input int i);
        return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
    endfunction

    function automatic int pd(input int i);
        return (i < pulse_dir.size()) ? pulse_dir[i] : -1;
    endfunction

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        dbl_pulse = 0;
        ud_bad    = 0;
        held_seen = 0;
        prev_step = 1'b0;
        prev_ud   = 1'b1;
        reset     = 1'b0;
        enable    = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;

        // Reset state
        run(2);
        chk("rst_step_en", int'(step_en), 0);
        chk("rst_up_down", int'(up_down), 1);
        chk("rst_held", int'(held), 0);
        reset = 1'b1;
        run(3);

        // Clean up press, 10 cycles
        clear_log();
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(10);
        btn_up = 1'b0;
        run(12);
        chk("clean_up_count", pulse_cyc.size(), 1);
        chk("clean_up_time", pc(0), p0 + 7);
        chk("clean_up_dir", pd(0), 1);

        // Bouncing down press, timed from the last bounce
        clear_log();
        btn_down = 1'b1; tick();
        btn_down = 1'b0; tick();
        btn_down = 1'b1; tick();
        btn_down = 1'b0; tick();
        btn_down = 1'b1;
        p0 = cyc + 1;
        run(10);
        btn_down = 1'b0;
        run(12);
        chk("bounce_dn_count", pulse_cyc.size(), 1);
        chk("bounce_dn_time", pc(0), p0 + 7);
        chk("bounce_dn_dir", pd(0), 0);
        chk("bounce_dn_ud_after", int'(up_down), 0);

        // Debounce boundary: 4-cycle press is too short, 5-cycle qualifies
        clear_log();
        btn_up = 1'b1;
        run(4);
        btn_up = 1'b0;
        run(10);
        chk("short4_count", pulse_cyc.size(), 0);
        clear_log();
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(5);
        btn_up = 1'b0;
        run(12);
        chk("short5_count", pulse_cyc.size(), 1);
        chk("short5_time", pc(0), p0 + 7);

        // Long hold: fire plus repeats at 20, 25, 30, 35; released before 40
        clear_log();
        exp_off[0] = 0;  exp_off[1] = 20; exp_off[2] = 25;
        exp_off[3] = 30; exp_off[4] = 35;
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(45);
        btn_up = 1'b0;
        run(12);
        chk("hold_count", pulse_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_time%0d", i), pc(i), p0 + 7 + exp_off[i]);
            chk($sformatf("hold_dir%0d", i), pd(i), 1);
        end

        // Other button during REPEAT stops pulses until full release
        clear_log();
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(29);
        btn_down = 1'b1;
        run(15);
        chk("interf_count", pulse_cyc.size(), 2);
        chk("interf_time0", pc(0), p0 + 7);
        chk("interf_time1", pc(1), p0 + 27);
        btn_down = 1'b0;
        run(10);
        chk("interf_up_still_held", pulse_cyc.size(), 2);
        btn_up = 1'b0;
        run(10);
        chk("interf_released", pulse_cyc.size(), 2);
        clear_log();
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(10);
        btn_up = 1'b0;
        run(12);
        chk("interf_fresh_count", pulse_cyc.size(), 1);
        chk("interf_fresh_time", pc(0), p0 + 7);

        // Both buttons together
        clear_log();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        run(10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        run(10);
        chk("both_count", pulse_cyc.size(), 0);
        chk("both_held", held_seen, 0);

        // enable low blocks the press; raising it with the button held
        // starts debounce from the synchronized level
        clear_log();
        enable = 1'b0;
        btn_up = 1'b1;
        run(12);
        chk("en_low_count", pulse_cyc.size(), 0);
        chk("en_low_held", held_seen, 0);
        enable = 1'b1;
        p0 = cyc + 1;
        run(10);
        btn_up = 1'b0;
        run(12);
        chk("en_rise_count", pulse_cyc.size(), 1);
        chk("en_rise_time", pc(0), p0 + 5);

        // Reset during HOLD_WAIT with the button still held
        clear_log();
        btn_up = 1'b1;
        p0 = cyc + 1;
        run(12);
        reset = 1'b0;
        run(2);
        chk("midrst_step_en", int'(step_en), 0);
        chk("midrst_up_down", int'(up_down), 1);
        chk("midrst_held", int'(held), 0);
        reset = 1'b1;
        p0 = cyc + 1;
        run(10);
        chk("midrst_count", pulse_cyc.size(), 2);
        chk("midrst_fresh_time", pc(1), p0 + 7);
        btn_up = 1'b0;
        run(12);

        // Invariants across the whole run
        chk("no_double_pulse", dbl_pulse, 0);
        chk("up_down_only_with_pulse", ud_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
